// File: rtl/stamp_capture_fifo_pkg.sv
// Shared definitions for the timestamp capture FIFO: default sizes, sender states and
// the HI-byte layout.
package stamp_capture_fifo_pkg;

  localparam int unsigned STAMP_W_DEFAULT = 14;
  localparam int unsigned DEPTH_DEFAULT   = 8;
  localparam logic        HI_MARKER       = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StSendHi,
    StWaitHi,
    StSendLo,
    StWaitLo
  } tx_state_e;

  // HI byte: marker bit, overflow flag, then the top six stamp bits.
  function automatic logic [7:0] hi_byte(input logic ovf, input logic [13:0] s);
    return {HI_MARKER, ovf, s[13:8]};
  endfunction

endpackage

// File: rtl/stamp_fifo.sv
// Power-of-two FIFO holding captured stamps. A push is ignored when full and a
// pop is ignored when empty; storage itself is not reset.
module stamp_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == FullLevel);
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr_q];
  assign level   = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/stamp_capture_fifo.sv
// Captures the phase counter on each rising edge of an asynchronous event, queues it,
// and streams each entry to a byte transmitter as a HI/LO pair with rts handshaking.
module stamp_capture_fifo
  import stamp_capture_fifo_pkg::*;
#(
  parameter int unsigned STAMP_W = STAMP_W_DEFAULT,
  parameter int unsigned DEPTH   = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   external,
  input  logic [STAMP_W-1:0]     stamp,
  input  logic                   rts,
  output logic [7:0]             data,
  output logic                   dataready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  logic       sync1_q, sync2_q, prev_q, armed_q;
  logic [1:0] fill_q;
  logic       cap, push, drop, pop, full, empty;

  logic [STAMP_W-1:0] rdata, entry_q;
  tx_state_e          state_q;
  logic [7:0]         data_q;
  logic               dataready_q, seen_low_q, report_q, overflow_q;
  logic [13:0]        entry14;
  logic               unused_entry_hi;

  // Arming waits until the synchroniser holds a real pin sample and that sample is
  // low, so a line already high at reset release cannot fake a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= external;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
      if (fill_q == 2'd2 && !sync2_q) armed_q <= 1'b1;
    end
  end

  assign cap  = sync2_q & ~prev_q & armed_q;
  assign push = cap & ~full;
  assign drop = cap & full;
  assign pop  = (state_q == StIdle) && !empty && rts;

  stamp_fifo #(
    .WIDTH (STAMP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (stamp),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign entry14         = 14'(entry_q);
  assign unused_entry_hi = ^entry14[13:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      entry_q     <= '0;
      data_q      <= 8'h00;
      dataready_q <= 1'b0;
      seen_low_q  <= 1'b0;
      report_q    <= 1'b0;
    end else begin
      dataready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            entry_q     <= rdata;
            data_q      <= hi_byte(overflow_q, 14'(rdata));
            dataready_q <= 1'b1;
            report_q    <= overflow_q;
            state_q     <= StSendHi;
          end
        end
        StSendHi: begin
          seen_low_q <= ~rts;
          state_q    <= StWaitHi;
        end
        StWaitHi: begin
          if (!rts) begin
            seen_low_q <= 1'b1;
          end else if (seen_low_q) begin
            data_q      <= entry14[7:0];
            dataready_q <= 1'b1;
            state_q     <= StSendLo;
          end
        end
        StSendLo: begin
          seen_low_q <= ~rts;
          state_q    <= StWaitLo;
        end
        StWaitLo: begin
          if (!rts) begin
            seen_low_q <= 1'b1;
          end else if (seen_low_q) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Only the flag value latched into the HI byte is cleared; a drop in the
  // reporting cycle itself keeps it set for the next entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (state_q == StSendHi && report_q) begin
      overflow_q <= 1'b0;
    end
  end

  assign data      = data_q;
  assign dataready = dataready_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/stamp_capture_fifo.md
STAMP_CAPTURE_FIFO -- requirements
Module: stamp_capture_fifo

Interface
REQ-001 Parameter: STAMP_W, 14, width of captured phase count.
REQ-002 Parameter: DEPTH, 8, FIFO entries; power of two, 2..64.
REQ-003 clk  in  1  system clock; the block's only clock.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 external  in  1  asynchronous capture event; rising edge triggers a capture.
REQ-006 stamp  in  STAMP_W  phase counter value, synchronous to clk.
REQ-007 rts  in  1  transmitter ready; high = idle and able to accept a byte.
REQ-008 data  out  8  byte presented to the transmitter.
REQ-009 dataready  out  1  one-cycle byte-valid strobe to the transmitter.
REQ-010 level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 overflow  out  1  sticky flag: at least one capture was dropped since last report.

Function
REQ-012 external passes through a 2-flop synchroniser, then a rising-edge detector; one capture pulse per rising edge, 3 clk after the edge at the pin.
REQ-013 On a capture pulse with FIFO not full, stamp (as sampled that cycle) is written; level increments next cycle.
REQ-014 On a capture pulse with FIFO full, the sample is dropped, and overflow sets next cycle; full is evaluated before any same-cycle pop.
REQ-015 FIFO order is strict first-in-first-out; pointers wrap modulo DEPTH; level ranges 0..DEPTH.
REQ-016 Simultaneous push (not full) and pop: level unchanged, both operations take effect.
REQ-017 Each entry transmits as two bytes: HI = {1'b1, overflow, stamp[13:8]}; LO = stamp[7:0].
REQ-018 Sender FSM states: IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO.
REQ-019 IDLE -> SEND_HI when level>0 and rts=1; the head entry is popped and held in a 14-bit register at this transition.
REQ-020 SEND_HI: data=HI byte, dataready=1 for exactly one cycle; -> WAIT_HI.
REQ-021 WAIT_HI: hold data; wait for rts=0 followed by rts=1, then -> SEND_LO.
REQ-022 SEND_LO: data=LO byte, dataready=1 for one cycle; -> WAIT_LO.
REQ-023 WAIT_LO: wait for rts=0 followed by rts=1, then -> IDLE.
REQ-024 overflow clears in the SEND_HI cycle that reports it, unless a drop occurs in that same cycle, in which case it stays set.
REQ-025 dataready is never asserted while rts=0, nor in two consecutive cycles.
REQ-026 data holds its last value outside SEND states.

Reset
REQ-027 rst_n low asynchronously forces: FSM=IDLE, FIFO pointers=0, level=0, overflow=0, dataready=0, data=8'h00, synchroniser flops=0.
REQ-028 Reset mid-transfer abandons the entry in flight and any queued entries; no byte is emitted until level>0 again after reset release.
REQ-029 A high external level at reset release does not create a capture until it falls and rises again.

Structure
REQ-030 A shared package holds STAMP_W, DEPTH defaults, the FSM state enum, and HI-byte marker constant 1'b1.
REQ-031 The FIFO storage and pointers are one sub-module, stamp_fifo (push, pop, wdata, rdata, full, empty, level).
REQ-032 The synchroniser, edge detector, and sender FSM live in stamp_capture_fifo.

Verification
REQ-033 Single capture: stamp=14'h2A5C, one external pulse, rts idle high with tx model -> bytes 8'hAA then 8'h5C, each with one dataready pulse.
REQ-034 Burst: 8 captures (stamps 0..7) with rts held low -> level=8; release rts -> 16 bytes in order 80,00,80,01,...,80,07.
REQ-035 Overflow: 9 captures with rts low -> level=8, overflow=1; first HI byte sent has bit6=1, overflow=0 afterwards, the 9th stamp is never sent.
REQ-036 Simultaneous push/pop at level=DEPTH-1 during IDLE->SEND_HI -> level stays DEPTH-1, no drop.
REQ-037 Reset asserted in WAIT_HI -> data=00, dataready=0, level=0 immediately; LO byte is never sent.
REQ-038 external held high across reset release -> no capture; falling then rising edge -> exactly one capture.
